// File: rtl/servo_ramp_pkg.sv
// servo_ramp_pkg: types and constants shared by servo_ramp and the PWM stage.
//   servo_state_e   : ramp FSM state (IDLE, RAMP)
//   SERVO_*         : frame length and pulse-width limits in microseconds
//   clamp_us()      : saturate a requested width into [lo, hi]
package servo_ramp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } servo_state_e;

    localparam int SERVO_FRAME_US  = 20000;
    localparam int SERVO_MIN_US    = 1000;
    localparam int SERVO_MAX_US    = 2000;
    localparam int SERVO_CENTER_US = 1500;

    function automatic logic [15:0] clamp_us(input logic [15:0] v,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/servo_ramp_if.sv
// servo_ramp_if: target-width valid/ready channel into servo_ramp.
//   target_us    : requested pulse width (us), producer -> ramp
//   target_valid : target_us valid this cycle, producer -> ramp
//   target_ready : ramp accepts a target this cycle, ramp -> producer
interface servo_ramp_if;
    logic [15:0] target_us;
    logic        target_valid;
    logic        target_ready;

    modport master (output target_us, output target_valid, input  target_ready);
    modport slave  (input  target_us, input  target_valid, output target_ready);
endinterface

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: 1 us prescaler plus frame counter.
//   CLK, RST   : clock, asynchronous active-high reset
//   us_tick    : combinational, high in the last CLK of each microsecond
//   frame_tick : registered one-CLK pulse in the cycle after the frame counter wraps
module servo_frame_timer #(
    parameter int CLK_F    = 100,
    parameter int FRAME_US = 20000
) (
    input  logic CLK,
    input  logic RST,
    output logic us_tick,
    output logic frame_tick
);
    localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
    localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          frame_tick_q, frame_tick_d;
    logic          frame_last;

    always_comb begin
        us_tick      = (presc_q == PW'(CLK_F - 1));
        frame_last   = (frame_q == FW'(FRAME_US - 1));
        presc_d      = us_tick ? '0 : presc_q + 1'b1;
        frame_d      = frame_q;
        frame_tick_d = 1'b0;
        if (us_tick) begin
            frame_d      = frame_last ? '0 : frame_q + 1'b1;
            frame_tick_d = frame_last;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q      <= '0;
            frame_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            frame_q      <= frame_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: clamps requested servo widths and slews pulse_len toward them
// by at most STEP_US per frame, changing only at frame boundaries.
//   CLK, RST   : clock, asynchronous active-high reset
//   tgt        : target_us / target_valid / target_ready channel (slave)
//   pulse_len  : current pulse width (us) to the PWM stage
//   busy       : high while pulse_len differs from the latched target
//   at_target  : one-CLK pulse when pulse_len lands on the target
//   frame_tick : one-CLK pulse at each frame boundary
module servo_ramp
    import servo_ramp_pkg::*;
#(
    parameter int CLK_F    = 100,
    parameter int FRAME_US = SERVO_FRAME_US,
    parameter int MIN_US   = SERVO_MIN_US,
    parameter int MAX_US   = SERVO_MAX_US,
    parameter int STEP_US  = 10
) (
    input  logic               CLK,
    input  logic               RST,
    servo_ramp_if.slave        tgt,
    output logic        [15:0] pulse_len,
    output logic               busy,
    output logic               at_target,
    output logic               frame_tick
);
    localparam logic [15:0] MIN_V    = 16'(MIN_US);
    localparam logic [15:0] MAX_V    = 16'(MAX_US);
    localparam logic [15:0] CENTER_V = 16'((MIN_US + MAX_US) / 2);
    localparam logic [15:0] STEP_V   = 16'(STEP_US);

    servo_state_e state_q, state_d;
    logic [15:0]  pulse_q, pulse_d;
    logic [15:0]  target_q, target_d;
    logic         busy_q, busy_d;
    logic         at_target_q, at_target_d;

    logic         us_tick_unused;
    logic         xfer;
    logic [15:0]  clamped;
    logic signed [16:0] diff;
    logic [16:0]  mag;

    servo_frame_timer #(.CLK_F(CLK_F), .FRAME_US(FRAME_US)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .us_tick    (us_tick_unused),
        .frame_tick (frame_tick)
    );

    // No back-pressure: every offered target is taken.
    assign tgt.target_ready = 1'b1;

    always_comb begin
        xfer    = tgt.target_valid;
        clamped = clamp_us(tgt.target_us, MIN_V, MAX_V);
        // Step uses the target latched before this cycle, so a transfer
        // coinciding with frame_tick only affects the following frame.
        diff    = $signed({1'b0, target_q}) - $signed({1'b0, pulse_q});
        mag     = diff[16] ? 17'(-diff) : 17'(diff);

        state_d     = state_q;
        pulse_d     = pulse_q;
        target_d    = target_q;
        busy_d      = busy_q;
        at_target_d = 1'b0;

        if (xfer) target_d = clamped;

        case (state_q)
            IDLE: begin
                if (xfer && clamped != pulse_q) begin
                    state_d = RAMP;
                    busy_d  = 1'b1;
                end
            end
            RAMP: begin
                if (frame_tick) begin
                    if (mag <= 17'(STEP_V)) begin
                        pulse_d = target_q;
                        // Landing on the old target while a different new one
                        // arrives: keep ramping instead of announcing arrival.
                        if (!(xfer && clamped != target_q)) begin
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            at_target_d = 1'b1;
                        end
                    end else if (diff[16]) begin
                        pulse_d = pulse_q - STEP_V;
                    end else begin
                        pulse_d = pulse_q + STEP_V;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            pulse_q     <= CENTER_V;
            target_q    <= CENTER_V;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

    assign pulse_len = pulse_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;
endmodule

// File: tb/tb_servo_ramp.sv
// tb_servo_ramp: directed, table-driven check of servo_ramp with a short
// frame (CLK_F=3, FRAME_US=10 -> 30 CLKs per frame) so ramps stay cheap.
module tb_servo_ramp;
    localparam int CLK_F    = 3;
    localparam int FRAME_US = 10;
    localparam int FRAME_CLK = CLK_F * FRAME_US;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] pulse_len;
    logic        busy, at_target, frame_tick;

    servo_ramp_if tif ();

    servo_ramp #(.CLK_F(CLK_F), .FRAME_US(FRAME_US), .MIN_US(1000),
                 .MAX_US(2000), .STEP_US(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tgt        (tif.slave),
        .pulse_len  (pulse_len),
        .busy       (busy),
        .at_target  (at_target),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] tgt;
        logic [15:0] final_us;
        int          frames;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at #1 after the posedge that starts a frame_tick cycle.
    task automatic wait_ft(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK + 5; i++) begin
            @(posedge CLK); #1;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL frame_tick_timeout: got none expected pulse within %0d clks", 2 * FRAME_CLK + 5);
        end
    endtask

    task automatic send(input logic [15:0] v);
        tif.target_us    = v;
        tif.target_valid = 1'b1;
        @(posedge CLK); #1;
        tif.target_valid = 1'b0;
    endtask

    task automatic do_frame(input string name, input logic [15:0] exp, input bit last);
        bit ok;
        wait_ft(ok);
        @(posedge CLK); #1;
        chk({name, "_pulse"}, pulse_len, exp);
        chk({name, "_at_target"}, at_target, last);
        chk({name, "_busy"}, busy, !last);
        if (last) begin
            @(posedge CLK); #1;
            chk({name, "_at_target_drop"}, at_target, 0);
        end
    endtask

    initial begin
        int          n;
        int          cur;
        int          model;
        int          seen;
        bit          ok;

        tif.target_us    = 16'd0;
        tif.target_valid = 1'b0;

        vecs[0] = '{16'd1600, 16'd1600, 10};   // up ramp
        vecs[1] = '{16'd500,  16'd1000, 60};   // clamp low, down ramp
        vecs[2] = '{16'd1005, 16'd1005, 1};    // single partial step
        vecs[3] = '{16'd2500, 16'd2000, 100};  // clamp high, final step of 5
        vecs[4] = '{16'd2000, 16'd2000, 0};    // equal target: stays idle
        vecs[5] = '{16'd1500, 16'd1500, 50};   // back to center

        // Reset asserted between edges; outputs must follow at once.
        #2 RST = 1'b1;
        #1;
        chk("rst_pulse", pulse_len, 1500);
        chk("rst_busy", busy, 0);
        chk("rst_at_target", at_target, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_ready", tif.target_ready, 1);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;

        n = 0;
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            @(posedge CLK); #1;
            n++;
            if (frame_tick) break;
        end
        chk("first_frame_tick_clks", n, FRAME_CLK);

        // Table-driven ramps.
        cur = 1500;
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].tgt);
            chk($sformatf("v%0d_busy_start", v), busy, vecs[v].frames > 0);
            model = cur;
            for (int f = 1; f <= vecs[v].frames; f++) begin
                if (model - int'(vecs[v].final_us) <= 10 && int'(vecs[v].final_us) - model <= 10)
                    model = vecs[v].final_us;
                else if (model < int'(vecs[v].final_us))
                    model += 10;
                else
                    model -= 10;
                do_frame($sformatf("v%0d_f%0d", v, f), 16'(model), f == vecs[v].frames);
            end
            if (vecs[v].frames == 0) begin
                wait_ft(ok);
                @(posedge CLK); #1;
                chk($sformatf("v%0d_idle_pulse", v), pulse_len, cur);
                chk($sformatf("v%0d_idle_at_target", v), at_target, 0);
            end
            chk($sformatf("v%0d_final", v), pulse_len, vecs[v].final_us);
            cur = vecs[v].final_us;
        end

        // Retarget mid-ramp: 1500 -> 1800, at 1530 switch to 1400.
        send(16'd1800);
        do_frame("rt_up1", 16'd1510, 1'b0);
        do_frame("rt_up2", 16'd1520, 1'b0);
        do_frame("rt_up3", 16'd1530, 1'b0);
        send(16'd1400);
        for (int k = 1; k <= 13; k++)
            do_frame($sformatf("rt_dn%0d", k), 16'(1530 - 10 * k), k == 13);

        // Transfer coinciding with frame_tick while ramping 1550 -> 1600.
        send(16'd1600);
        for (int k = 1; k <= 15; k++)
            do_frame($sformatf("sim_up%0d", k), 16'(1400 + 10 * k), 1'b0);
        wait_ft(ok);
        tif.target_us    = 16'd1200;
        tif.target_valid = 1'b1;
        @(posedge CLK); #1;
        tif.target_valid = 1'b0;
        chk("sim_old_target_step", pulse_len, 1560);
        chk("sim_busy", busy, 1);
        do_frame("sim_new1", 16'd1550, 1'b0);
        do_frame("sim_new2", 16'd1540, 1'b0);

        // Retarget to the current width while ramping: arrive without moving.
        send(16'd1540);
        do_frame("eq_retarget", 16'd1540, 1'b1);

        // Reset mid-ramp at 1700.
        send(16'd1800);
        for (int k = 1; k <= 16; k++)
            do_frame($sformatf("mr_up%0d", k), 16'(1540 + 10 * k), 1'b0);
        #3 RST = 1'b1;
        #1;
        chk("mr_rst_pulse", pulse_len, 1500);
        chk("mr_rst_busy", busy, 0);
        chk("mr_rst_at_target", at_target, 0);
        @(negedge CLK) RST = 1'b0;
        seen = 0;
        n    = 0;
        for (int i = 0; i < 3 * FRAME_CLK; i++) begin
            @(posedge CLK); #1;
            if (at_target) seen++;
            if (busy || pulse_len != 16'd1500) n++;
        end
        chk("mr_post_at_target_count", seen, 0);
        chk("mr_post_moved_cycles", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/servo_ramp.md
Name: servo_ramp

Overview:
- Upstream stage of the servo PWM generator; drives its 16-bit pulse_len input (microseconds).
- Accepts target pulse widths over a valid/ready handshake and clamps them to a safe range.
- Slews the output toward the target by a bounded step once per 20 ms servo frame, so the mechanism never sees a step change larger than STEP_US per period.
- Keeps its own frame timer, matched to the PWM period, so pulse_len changes only at frame boundaries.

Parameters:
- CLK_F, 100, CLK frequency in MHz; prescaler divides by this to get a 1 us tick.
- FRAME_US, 20000, frame length in us; must equal the PWM period.
- MIN_US, 1000, lowest allowed pulse_len.
- MAX_US, 2000, highest allowed pulse_len.
- STEP_US, 10, maximum change of pulse_len per frame; must be ≥1.

Ports:
- CLK, in, 1, system clock.
- RST, in, 1, asynchronous reset, active-high.
- target_us, in, 16, requested pulse width in us.
- target_valid, in, 1, target_us valid this cycle.
- target_ready, out, 1, block accepts a target this cycle.
- pulse_len, out, 16, current pulse width in us; feeds the PWM stage.
- busy, out, 1, high while pulse_len ≠ latched target.
- at_target, out, 1, one-cycle pulse when pulse_len reaches the target.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.

Behaviour:
Reset values (RST asserted, asynchronous):
- prescaler=0, frame counter=0.
- pulse_len = target = (MIN_US+MAX_US)/2, i.e. 1500.
- busy=0, at_target=0, frame_tick=0, state=IDLE.

Timing:
- us_tick fires when the prescaler reaches CLK_F-1; the prescaler then wraps to 0.
- The frame counter increments on each us_tick and wraps from FRAME_US-1 to 0.
- frame_tick is registered and asserts for one CLK on the cycle after the wrap.

Handshake:
- target_ready is 1 in every cycle after reset; a transfer occurs when target_valid=1.
- The captured value is clamped: below MIN_US gives MIN_US, above MAX_US gives MAX_US, otherwise unchanged.
- The clamped value overwrites the target register on the next edge.
- Retargeting mid-ramp is allowed: the ramp continues from the current pulse_len toward the new target with no reset of the ramp.

State machine:
- IDLE (pulse_len == target):
  - A transfer whose clamped value differs from pulse_len goes to RAMP, busy=1 on the next cycle.
  - A transfer with an equal value stays in IDLE; no at_target pulse.
- RAMP, on each frame_tick:
  - Compute d = target − pulse_len in 17-bit signed arithmetic.
  - If |d| ≤ STEP_US: pulse_len ← target, go to IDLE, at_target=1 for one cycle, busy=0.
  - Otherwise pulse_len ← pulse_len ± STEP_US, toward the target.
- pulse_len never leaves [MIN_US, MAX_US] and never overshoots the target.

Simultaneous events:
- A transfer in the same cycle as frame_tick: the step uses the old target; the new target applies from the next frame.
- Retarget to a value equal to the current pulse_len while in RAMP: next frame_tick goes to IDLE with an at_target pulse, and pulse_len is unchanged.

Latency:
- A target change appears on pulse_len at the first frame_tick after acceptance at the earliest.
- Full travel takes ceil(|Δ|/STEP_US) frames.

Reset mid-ramp:
- Immediately returns to the reset values above; the pending target is discarded.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RAMP);
  - constants SERVO_FRAME_US=20000, SERVO_MIN_US=1000, SERVO_MAX_US=2000, SERVO_CENTER_US=1500, shared with the PWM stage.
- One natural sub-module: servo_frame_timer (prescaler + frame counter, outputs us_tick and frame_tick).
  - Reusable by the PWM stage so both share the same period.

Test Plan:
- Reset: assert RST mid-frame. Required: pulse_len=1500, busy=0, at_target=0 immediately (asynchronous); first frame_tick exactly 2,000,000 CLKs after RST deasserts.
- Up ramp: accept 1600 from 1500. Required: busy=1; pulse_len=1510,1520,…,1600 on 10 consecutive frame_ticks; at_target pulses once with the last step; busy=0.
- Clamping and partial step: accept 500. Required: target becomes 1000; ramp down by 10 per frame. Then accept 2500 from 1005. Required: target becomes 2000, and 1005 reaches 2000 with a final step of 5, no overshoot.
- Retarget mid-ramp: 1500→1800, after 3 frames (1530) accept 1400. Required: next frames give 1520,1510,…,1400 with no discontinuity; exactly one at_target.
- Simultaneous transfer: target_valid coincides with frame_tick while ramping toward 1600 from 1550. Required: that frame steps to 1560 toward the old target; the new target governs from the next frame_tick.
- Reset mid-ramp: RST during a ramp at 1700. Required: pulse_len returns to 1500 asynchronously; no at_target pulse; the pending target is discarded.
